// File: rtl/reg_univ.sv
// reg_univ: universal register (hold/load/shift/rotate/clear/set, mode 0-7) with a saturating shift count cnt, done at cnt==WIDTH, serial outs sout_l/sout_r, async active-low rst_n; define REG_UNIV_QN_EN to add the qn=~q port
module reg_univ #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_r,
    input  logic                         sin_l,
    output logic [WIDTH-1:0]             q,
`ifdef REG_UNIV_QN_EN
    output logic [WIDTH-1:0]             qn,
`endif
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         done
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0] cnt_nxt;
    logic shift, restart;
    always_comb begin
        shift   = mode >= 3'd2 && mode <= 3'd5;
        restart = mode == 3'd1 || mode >= 3'd6;
        q_nxt = mode == 3'd1 ? d :
                mode == 3'd2 ? {q[WIDTH-2:0], sin_r} :
                mode == 3'd3 ? {sin_l, q[WIDTH-1:1]} :
                mode == 3'd4 ? {q[WIDTH-2:0], q[WIDTH-1]} :
                mode == 3'd5 ? {q[0], q[WIDTH-1:1]} :
                mode == 3'd6 ? '0 :
                mode == 3'd7 ? '1 : q;
        cnt_nxt = restart ? '0 : (shift && !done) ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= RST_VAL;
            cnt <= '0;
        end else begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end
    assign done   = cnt == CW'(WIDTH);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
`ifdef REG_UNIV_QN_EN
    assign qn = ~q;
`endif
endmodule

// File: tb/tb_reg_univ.sv
// tb_reg_univ: directed self-checking bench for reg_univ (WIDTH=8, RST_VAL=A5)
module tb_reg_univ;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic sin_r = 1'b0;
    logic sin_l = 1'b0;
    logic [7:0] q;
`ifdef REG_UNIV_QN_EN
    logic [7:0] qn;
`endif
    logic sout_l, sout_r, done;
    logic [3:0] cnt;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_sl = 8'b1000_0001;
    logic [7:0] exp_rr [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

    reg_univ #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l), .q(q),
`ifdef REG_UNIV_QN_EN
        .qn(qn),
`endif
        .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] m, input logic [7:0] dv, input logic sr, input logic sl);
        mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", q, 8'hA5);
`ifdef REG_UNIV_QN_EN
        check("rst_qn", qn, 8'h5A);
`endif
        check("rst_cnt", cnt, 0);
        check("rst_done", done, 0);
        check("rst_sout", {sout_l, sout_r}, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'd0, 8'h00, 0, 0);
        check("hold_after_rst", q, 8'hA5);

        step(3'd1, 8'h81, 0, 0);
        check("load81", q, 8'h81);
        check("load81_cnt", cnt, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sout_l_%0d", i), sout_l, exp_sl[7-i]);
            step(3'd2, 8'h00, 0, 0);
        end
        check("shl_q", q, 8'h00);
        check("shl_cnt", cnt, 8);
        check("shl_done", done, 1);

        for (int i = 0; i < 3; i++) step(3'd3, 8'h00, 0, 1);
        check("sat_q", q, 8'hE0);
        check("sat_cnt", cnt, 8);
        check("sat_done", done, 1);

        step(3'd1, 8'h01, 0, 0);
        check("load01_done", done, 0);
        for (int i = 0; i < 9; i++) begin
            step(3'd5, 8'h00, 0, 0);
            check($sformatf("ror_%0d", i), q, exp_rr[i]);
        end
        check("ror_cnt", cnt, 8);
        check("ror_sout_r", sout_r, 0);
        step(3'd4, 8'h00, 0, 0);
        check("rol_q", q, 8'h01);
        step(3'd1, 8'h3C, 0, 0);
        check("load3c_q", q, 8'h3C);
        check("load3c_cnt", cnt, 0);
        check("load3c_done", done, 0);

        step(3'd7, 8'h00, 0, 0);
        check("set_q", q, 8'hFF);
        check("set_cnt", cnt, 0);
        for (int i = 0; i < 5; i++) step(3'd0, 8'h12, 1, 1);
        check("hold_q", q, 8'hFF);
        check("hold_cnt", cnt, 0);
        step(3'd6, 8'h00, 0, 0);
        check("clr_q", q, 8'h00);
`ifdef REG_UNIV_QN_EN
        check("clr_qn", qn, 8'hFF);
`endif

        step(3'd1, 8'hF0, 0, 0);
        for (int i = 0; i < 3; i++) step(3'd2, 8'h00, 0, 0);
        check("mid_q", q, 8'h80);
        check("mid_cnt", cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q", q, 8'hA5);
        check("mid_rst_cnt", cnt, 0);
        #1 rst_n = 1'b1;
        step(3'd2, 8'h00, 1, 0);
        check("post_rst_shl", q, 8'h4B);
        check("post_rst_cnt", cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_univ.md
# reg_univ

Parametrised universal register, the multi-bit successor of the single-bit D flip-flop. It holds a WIDTH-bit word that can be held, parallel-loaded, shifted or rotated in either direction, or synchronously cleared or set, all selected by a 3-bit mode code. A saturating shift counter and a `done` flag let it act as a parallel-to-serial or serial-to-parallel converter. It is used as the generic storage and serialisation element in lab designs.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal values are 2 or more.
- `RST_VAL`, default 0: value of `q` after asynchronous reset, WIDTH bits wide.

Ports:
- `clk`  input  1: clock; all state changes on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `mode`  input  3: operation select (see Operation).
- `d`  input  WIDTH: parallel load data.
- `sin_r`  input  1: serial input entering bit 0 on shift left.
- `sin_l`  input  1: serial input entering bit WIDTH-1 on shift right.
- `q`  output  WIDTH: register contents.
- `qn`  output  WIDTH: equal to `~q`; present only with REG_UNIV_QN_EN.
- `sout_l`  output  1: equal to `q[WIDTH-1]`.
- `sout_r`  output  1: equal to `q[0]`.
- `cnt`  output  $clog2(WIDTH+1): number of shifts since the last load, clear or set; saturates.
- `done`  output  1: high when `cnt == WIDTH`.

## Operation
- Mode codes, applied at the rising edge of `clk`:
  - 000 hold: `q` unchanged, `cnt` unchanged.
  - 001 load: `q <= d`, `cnt <= 0`.
  - 010 shift left: `q <= {q[WIDTH-2:0], sin_r}`, `cnt` increments.
  - 011 shift right: `q <= {sin_l, q[WIDTH-1:1]}`, `cnt` increments.
  - 100 rotate left: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`, `cnt` increments.
  - 101 rotate right: `q <= {q[0], q[WIDTH-1:1]}`, `cnt` increments.
  - 110 synchronous clear: `q <= 0`, `cnt <= 0`.
  - 111 synchronous set: `q <= all ones`, `cnt <= 0`.
- `cnt` saturates at WIDTH. Further shifts or rotates still move data, but `cnt` stays at WIDTH and `done` stays high.
- `done` is a combinational decode of `cnt`. It falls on the edge that applies a load, clear or set.
- There is no X-propagation special case; every mode code is defined.

## Timing
- Reset: when `rst_n` goes low, immediately and independent of `clk`, `q` = RST_VAL, `cnt` = 0 and `done` = 0. `sout_l` and `sout_r` follow RST_VAL.
- Reset asserted mid-shift aborts the operation with no partial update. The first edge after `rst_n` rises operates on RST_VAL.
- `rst_n` deasserts synchronously to `clk`; this is the integrator's responsibility.
- Latency: one cycle from `mode`/`d`/`sin_*` sampled at edge N to `q`/`cnt` valid after edge N.
- `sout_l`, `sout_r`, `qn` and `done` are combinational from registered state and carry no extra latency.
- Serialising WIDTH bits: one load, then WIDTH consecutive shift edges. `done` goes high after the WIDTH-th shift edge.
- `mode` may change on every cycle. No back-to-back restrictions apply.

## Configuration
- `REG_UNIV_QN_EN` defined: port `qn` exists and equals `~q`. This is the complemented output kept from the flip-flop generation.
- Not defined: port `qn` and its logic are absent. All other behaviour is identical.

## Test plan
Bench configuration: WIDTH=8, RST_VAL=8'hA5, REG_UNIV_QN_EN defined.
- Reset: drive `rst_n`=0 between edges -> `q`=A5, `qn`=5A, `cnt`=0, `done`=0 with no clock edge needed. Then release `rst_n` with mode 000 -> `q` holds A5.
- Load then shift left: load 8'h81, then 8 shift-left edges with `sin_r`=0 -> `sout_l` sequence 1,0,0,0,0,0,0,1 before each edge. End state `q`=00, `cnt`=8, `done`=1.
- Saturation: starting from `cnt`=8, 3 more shift-right edges with `sin_l`=1 -> `q`=E0, `cnt` stays 8, `done` stays 1.
- Rotate: load 8'h01, then 9 rotate-right edges -> after the first edge `q`=80, after the ninth `q`=80, `cnt`=8. A load with `d`=3C -> `cnt`=0, `done`=0.
- Clear/set/hold: mode 111 -> `q`=FF, `cnt`=0. Mode 000 for 5 edges -> `q`=FF. Mode 110 -> `q`=00.
- Reset mid-serialisation: load 8'hF0, 3 shift-left edges, then pulse `rst_n` low -> `q`=A5, `cnt`=0 at once. The next shift-left with `sin_r`=1 gives `q`=4B.
